// File: rtl/threshold_fifo.sv
// Single-clock FIFO with occupancy threshold flags, used to move whole records
// (triangles, fragments) of threshold_level words between pipeline stages.
module threshold_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [31:0]           threshold_level,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  fifo_lower_threshold,
   output logic                  fifo_upper_threshold,
   output logic                  fifo_overflow,
   output logic                  fifo_underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]           r_wr_ptr, r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_q;
   logic                  r_ovf, r_udf;

   logic [AW:0] w_count;
   logic        w_full, w_empty, w_wr_acc, w_rd_acc, w_we;
   logic [32:0] w_cnt33, w_thr33;

   assign w_count  = r_wr_ptr - r_rd_ptr;
   assign w_full   = (w_count == (AW+1)'(DEPTH));
   assign w_empty  = (w_count == '0);
   // A write into a full FIFO is fine when the head is popped on the same edge.
   assign w_wr_acc = wr && (!w_full || rd);
   assign w_rd_acc = rd && !w_empty;
   assign w_we     = w_wr_acc && !resetn;

   // Storage array: no reset; the read on a full rd+wr sees the old word.
   always_ff @(posedge clk) begin
      if (w_we)
         r_mem[r_wr_ptr[AW-1:0]] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_q      <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_wr_acc)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_q      <= r_mem[r_rd_ptr[AW-1:0]];
         end
         r_ovf <= wr && !w_wr_acc;
         r_udf <= rd && !w_rd_acc;
      end
   end

   // 33-bit compares so large threshold values cannot wrap.
   assign w_cnt33 = 33'(w_count);
   assign w_thr33 = {1'b0, threshold_level};

   assign data_out             = r_q;
   assign fifo_full            = w_full;
   assign fifo_empty           = w_empty;
   assign fifo_lower_threshold = (w_cnt33 >= w_thr33);
   assign fifo_upper_threshold = ((w_cnt33 + w_thr33) > 33'(DEPTH));
   assign fifo_overflow        = r_ovf;
   assign fifo_underflow       = r_udf;

endmodule

// File: tb/tb_threshold_fifo.sv
// Directed bench for threshold_fifo (DEPTH=16): ordering, flags, thresholds,
// over/underflow pulses, full-throughput wrap and mid-stream reset.
module tb_threshold_fifo;

   logic        clk = 1'b0;
   logic        resetn, wr, rd;
   logic [31:0] data_in, threshold_level;
   logic [31:0] data_out;
   logic        fifo_full, fifo_empty, fifo_lower_threshold, fifo_upper_threshold;
   logic        fifo_overflow, fifo_underflow;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_w;

   threshold_fifo #(.DATA_WIDTH(32), .DEPTH(16)) dut (
      .clk(clk), .resetn(resetn), .wr(wr), .rd(rd),
      .data_in(data_in), .threshold_level(threshold_level),
      .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_lower_threshold(fifo_lower_threshold),
      .fifo_upper_threshold(fifo_upper_threshold),
      .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: present inputs, take the edge, settle 1 time unit past it.
   task automatic step(input logic w, input logic r, input logic [31:0] d);
      wr = w; rd = r; data_in = d;
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0; threshold_level = 32'd4;
      @(posedge clk); #1;
      resetn = 1'b0;
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full",  fifo_full, 0);
      chk("rst_dout",  data_out, 0);
      chk("rst_ovf",   fifo_overflow, 0);
      chk("rst_udf",   fifo_underflow, 0);
      chk("rst_lower", fifo_lower_threshold, 0);
      chk("rst_upper", fifo_upper_threshold, 0);

      // Fill 1..16 with threshold 4: lower at count>=4, upper at count>=13.
      for (int k = 1; k <= 16; k++) begin
         step(1, 0, k);
         chk("fill_empty", fifo_empty, 0);
         chk("fill_lower", fifo_lower_threshold, (k >= 4));
         chk("fill_upper", fifo_upper_threshold, (k >= 13));
         chk("fill_full",  fifo_full, (k == 16));
      end

      step(1, 0, 32'd99);
      chk("ovf_pulse", fifo_overflow, 1);
      chk("ovf_full",  fifo_full, 1);
      step(0, 0, 0);
      chk("ovf_clear", fifo_overflow, 0);

      for (int k = 1; k <= 16; k++) begin
         step(0, 1, 0);
         chk("drain_data", data_out, k);
         chk("drain_empty", fifo_empty, (k == 16));
      end

      step(0, 1, 0);
      chk("udf_pulse", fifo_underflow, 1);
      chk("udf_hold",  data_out, 16);
      step(0, 0, 0);
      chk("udf_clear", fifo_underflow, 0);

      step(1, 1, 32'hA5);
      chk("rw_empty_udf",   fifo_underflow, 1);
      chk("rw_empty_cnt",   fifo_empty, 0);
      chk("rw_empty_lower", fifo_lower_threshold, 0);
      chk("rw_empty_dout",  data_out, 16);
      step(0, 1, 0);
      chk("a5_data",  data_out, 32'hA5);
      chk("a5_empty", fifo_empty, 1);
      chk("a5_udf",   fifo_underflow, 0);

      threshold_level = 32'd0;          #1; chk("thr0_lower", fifo_lower_threshold, 1);
      threshold_level = 32'd16;         #1; chk("thr16_upper", fifo_upper_threshold, 0);
      threshold_level = 32'd17;         #1; chk("thr17_upper", fifo_upper_threshold, 1);
      threshold_level = 32'hFFFF_FFFF;  #1; chk("thrmax_upper", fifo_upper_threshold, 1);
      chk("thrmax_lower", fifo_lower_threshold, 0);
      threshold_level = 32'd4;

      // Full-throughput rd+wr across pointer wrap, scoreboard-checked.
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 32'h100 + i);
         sb.push_back(32'h100 + i);
      end
      for (int j = 0; j < 40; j++) begin
         step(1, 1, 32'h200 + j);
         sb.push_back(32'h200 + j);
         exp_w = sb.pop_front();
         chk("wrap_data", data_out, exp_w);
         chk("wrap_full", fifo_full, 1);
      end
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0);
         exp_w = sb.pop_front();
         chk("wrap_drain", data_out, exp_w);
      end
      chk("wrap_empty", fifo_empty, 1);

      // Reset while holding 7 words; rd/wr in the reset cycle are ignored.
      for (int i = 0; i < 7; i++) step(1, 0, 32'h300 + i);
      chk("pre_rst_lower", fifo_lower_threshold, 1);
      resetn = 1'b1;
      step(1, 1, 32'h55);
      resetn = 1'b0;
      chk("mrst_empty", fifo_empty, 1);
      chk("mrst_full",  fifo_full, 0);
      chk("mrst_dout",  data_out, 0);
      chk("mrst_ovf",   fifo_overflow, 0);
      chk("mrst_udf",   fifo_underflow, 0);
      chk("mrst_lower", fifo_lower_threshold, 0);
      step(1, 0, 32'h77);
      chk("post_rst_empty", fifo_empty, 0);
      step(0, 1, 0);
      chk("post_rst_data",  data_out, 32'h77);
      chk("post_rst_empty2", fifo_empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
